keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 163 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low rows, debounces the first low column, reports accepted keys.
// Latency: 2-clk column synchronizer plus DEBOUNCE_TICKS scan ticks to accept; key_valid is registered (one clk after the accepting tick).
// Backpressure: none; key_valid is a single-cycle pulse and key_code holds until the next accepted press.
module keypad_scanner #(
   parameter int SCAN_DIV       = 2500,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] keypad_col,
   output logic [3:0] keypad_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [3:0]  DEB_LAST = 4'(DEBOUNCE_TICKS);

   state_t      state, state_nxt;
   logic [3:0]  col_m, col_s;
   logic [15:0] tick_cnt;
   logic        tick;
   logic [1:0]  row_idx, row_idx_nxt;
   logic [1:0]  col_idx, col_idx_nxt;
   logic [3:0]  deb_cnt, deb_cnt_nxt, deb_inc;
   logic [3:0]  key_code_nxt;
   logic        key_valid_nxt, key_held_nxt;
   logic [1:0]  low_col;
   logic        col_low_any;
   logic        tracked_low;

   // Two-flop synchronizer for the asynchronous column sense lines (idle = pulled up).
   always_ff @(posedge clk) begin
      if (!reset) begin
         col_m <= 4'hF;
         col_s <= 4'hF;
      end else begin
         col_m <= keypad_col;
         col_s <= col_m;
      end
   end

   // Free-running scan-tick divider; runs regardless of FSM state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   assign tick        = (tick_cnt == DIV_LAST);
   assign col_low_any = (col_s != 4'hF);
   assign tracked_low = ~col_s[col_idx];
   assign deb_inc     = deb_cnt + 4'd1;
   assign keypad_row  = ~(4'b0001 << row_idx);

   // Lowest-index low column wins when several keys in the scanned row are down.
   always_comb begin
      low_col = 2'd0;
      if (!col_s[0])      low_col = 2'd0;
      else if (!col_s[1]) low_col = 2'd1;
      else if (!col_s[2]) low_col = 2'd2;
      else if (!col_s[3]) low_col = 2'd3;
   end

   // FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= SCAN;
         row_idx   <= 2'd0;
         col_idx   <= 2'd0;
         deb_cnt   <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nxt;
         row_idx   <= row_idx_nxt;
         col_idx   <= col_idx_nxt;
         deb_cnt   <= deb_cnt_nxt;
         key_code  <= key_code_nxt;
         key_valid <= key_valid_nxt;
         key_held  <= key_held_nxt;
      end
   end

   // Next-state logic: every decision is taken on a tick; only the latched column is tracked once a key is seen.
   always_comb begin
      state_nxt     = state;
      row_idx_nxt   = row_idx;
      col_idx_nxt   = col_idx;
      deb_cnt_nxt   = deb_cnt;
      key_code_nxt  = key_code;
      key_valid_nxt = 1'b0;
      key_held_nxt  = key_held;
      if (tick) begin
         case (state)
            SCAN: begin
               if (col_low_any) begin
                  col_idx_nxt = low_col;
                  deb_cnt_nxt = 4'd1;
                  if (DEB_LAST == 4'd1) begin
                     key_code_nxt  = {row_idx, low_col};
                     key_valid_nxt = 1'b1;
                     key_held_nxt  = 1'b1;
                     state_nxt     = HELD;
                  end else begin
                     state_nxt = DEBOUNCE;
                  end
               end else begin
                  row_idx_nxt = row_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (tracked_low) begin
                  deb_cnt_nxt = deb_inc;
                  if (deb_inc == DEB_LAST) begin
                     key_code_nxt  = {row_idx, col_idx};
                     key_valid_nxt = 1'b1;
                     key_held_nxt  = 1'b1;
                     state_nxt     = HELD;
                  end
               end else begin
                  state_nxt   = SCAN;
                  row_idx_nxt = row_idx + 2'd1;
               end
            end
            HELD: begin
               if (!tracked_low) begin
                  deb_cnt_nxt = 4'd1;
                  if (DEB_LAST == 4'd1) begin
                     state_nxt    = SCAN;
                     row_idx_nxt  = row_idx + 2'd1;
                     key_held_nxt = 1'b0;
                  end else begin
                     state_nxt = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (!tracked_low) begin
                  deb_cnt_nxt = deb_inc;
                  if (deb_inc == DEB_LAST) begin
                     state_nxt    = SCAN;
                     row_idx_nxt  = row_idx + 2'd1;
                     key_held_nxt = 1'b0;
                  end
               end else begin
                  state_nxt = HELD;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a 4x4 key matrix and compares every cycle against a tick-level reference model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: none; stimulus is a pressed-key mask held for a chosen number of clocks.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DT = 3;

   logic       clk;
   logic       reset;
   logic [3:0] keypad_col;
   logic [3:0] keypad_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] pressed;
   int          n_vec;
   int          n_err;
   int          pulses;
   logic [3:0]  rel_row;
   logic        prev_held;

   // Reference model state: abstract counters and flags, not the design's encoding.
   int         m_cnt;
   logic [3:0] m_sync1, m_sync2;
   int         m_row;
   int         m_ccol;
   bit         tracking;
   bit         accepted;
   int         press_streak;
   int         release_streak;
   logic [3:0] e_code;
   logic       e_valid;
   logic       e_held;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
      .clk        (clk),
      .reset      (reset),
      .keypad_col (keypad_col),
      .keypad_row (keypad_row),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_held   (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      keypad_col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && keypad_row[r] === 1'b0) keypad_col[c] = 1'b0;
   end

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void take_key();
      e_code   = 4'(m_row * 4 + m_ccol);
      e_valid  = 1'b1;
      accepted = 1'b1;
      release_streak = 0;
   endfunction

   // One rising clock edge of the reference model; cin is the column value sampled at that edge.
   function automatic void model_edge(input logic [3:0] cin, input logic rst);
      logic [3:0] cs;
      bit         tk;
      if (!rst) begin
         m_cnt = 0; m_sync1 = 4'hF; m_sync2 = 4'hF; m_row = 0; m_ccol = 0;
         tracking = 0; accepted = 0; press_streak = 0; release_streak = 0;
         e_code = 4'd0; e_valid = 1'b0; e_held = 1'b0;
         return;
      end
      cs = m_sync2;
      tk = (m_cnt == SD - 1);
      e_valid = 1'b0;
      if (tk) begin
         if (!tracking) begin
            if (cs != 4'hF) begin
               for (int c = 3; c >= 0; c--) if (!cs[c]) m_ccol = c;
               tracking = 1;
               press_streak = 1;
               if (press_streak >= DT) take_key();
            end else begin
               m_row = (m_row + 1) % 4;
            end
         end else if (!accepted) begin
            if (!cs[m_ccol]) begin
               press_streak++;
               if (press_streak >= DT) take_key();
            end else begin
               tracking = 0;
               m_row = (m_row + 1) % 4;
            end
         end else begin
            if (cs[m_ccol]) begin
               release_streak++;
               if (release_streak >= DT) begin
                  tracking = 0; accepted = 0; release_streak = 0;
                  m_row = (m_row + 1) % 4;
               end
            end else begin
               release_streak = 0;
            end
         end
      end
      e_held  = accepted;
      m_cnt   = (m_cnt + 1) % SD;
      m_sync2 = m_sync1;
      m_sync1 = cin;
   endfunction

   // Apply one clock of stimulus, advance the model, compare all outputs.
   task automatic step(input logic [15:0] p, input logic rst);
      logic [3:0] cin;
      logic [3:0] e_row;
      pressed = p;
      reset   = rst;
      #1;
      cin = keypad_col;
      @(posedge clk);
      model_edge(cin, rst);
      #1;
      e_row = ~(4'b0001 << m_row);
      chk("keypad_row", 16'(keypad_row), 16'(e_row));
      chk("key_code",   16'(key_code),   16'(e_code));
      chk("key_valid",  16'(key_valid),  16'(e_valid));
      chk("key_held",   16'(key_held),   16'(e_held));
      if (key_valid === 1'b1) pulses++;
      if (prev_held === 1'b1 && key_held === 1'b0) rel_row = keypad_row;
      prev_held = key_held;
   endtask

   task automatic run(input logic [15:0] p, input int n);
      for (int i = 0; i < n; i++) step(p, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_row"},   16'(keypad_row), 16'hE);
      chk({tag, "_code"},  16'(key_code),   16'h0);
      chk({tag, "_valid"}, 16'(key_valid),  16'h0);
      chk({tag, "_held"},  16'(key_held),   16'h0);
   endtask

   initial begin
      logic [15:0] p;
      int          dur;
      n_vec = 0; n_err = 0; pulses = 0; rel_row = 4'h0; prev_held = 1'b0;
      pressed = 16'h0; reset = 1'b0;

      // Reset state.
      step(16'h0, 1'b0);
      step(16'h0, 1'b0);
      chk_reset_vals("rst");

      // Idle scanning: rows walk, never a pulse.
      pulses = 0;
      run(16'h0, 20);
      chk("idle_pulses", 16'(pulses), 16'd0);

      // Row 2 / col 1 held then released.
      pulses = 0; rel_row = 4'h0;
      run(16'h1 << 9, 40);
      run(16'h0, 40);
      chk("r2c1_pulses", 16'(pulses), 16'd1);
      chk("r2c1_code", 16'(key_code), 16'd9);
      chk("r2c1_resume_row", 16'(rel_row), 16'h7);

      // Row 1 / col 2 bounce: single tick low, no acceptance.
      pulses = 0;
      for (int i = 0; i < 64 && keypad_row !== 4'b1101; i++) step(16'h0, 1'b1);
      chk("reach_row1", 16'(keypad_row), 16'hD);
      run(16'h1 << 6, 4);
      run(16'h0, 40);
      chk("bounce_pulses", 16'(pulses), 16'd0);
      chk("bounce_code", 16'(key_code), 16'd9);

      // Row 0 cols 0 and 3 together: lowest column wins.
      pulses = 0;
      run(16'h0009, 40);
      run(16'h0, 40);
      chk("multi_pulses", 16'(pulses), 16'd1);
      chk("multi_code", 16'(key_code), 16'd0);

      // Short release glitch while held, then full release and re-press.
      pulses = 0;
      run(16'h8000, 40);
      run(16'h0, 4);
      run(16'h8000, 20);
      chk("glitch_pulses", 16'(pulses), 16'd1);
      chk("glitch_held", 16'(key_held), 16'd1);
      run(16'h0, 40);
      chk("release_held", 16'(key_held), 16'd0);
      run(16'h8000, 40);
      chk("repress_pulses", 16'(pulses), 16'd2);
      chk("repress_code", 16'(key_code), 16'd15);
      run(16'h0, 40);

      // Reset during debounce.
      p = 16'h1 << 5;
      for (int i = 0; i < 64 && !(tracking && !accepted); i++) step(p, 1'b1);
      chk("reach_deb", 16'({tracking, accepted}), 16'b10);
      step(p, 1'b0);
      chk_reset_vals("rst_deb");

      // Reset while held.
      for (int i = 0; i < 64 && key_held !== 1'b1; i++) step(p, 1'b1);
      chk("reach_held", 16'(key_held), 16'd1);
      run(p, 2);
      step(p, 1'b0);
      chk_reset_vals("rst_held");
      run(16'h0, 20);

      // Randomized key activity against the model.
      for (int s = 0; s < 70; s++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5, 6, 7, 8, 9: p = 16'h0;
            10, 11, 12, 13, 14, 15, 16:   p = 16'h1 << $urandom_range(0, 15);
            default: p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
         endcase
         dur = $urandom_range(1, 40);
         if ($urandom_range(0, 29) == 0) step(p, 1'b0);
         run(p, dur);
      end
      run(16'h0, 30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
